wb_arbiter_rr: RTL

- Parametrised N-master to 1-slave Wishbone classic arbiter.
- Round-robin bus grant, held for the whole cycle (CYC), with a per-transfer watchdog that returns ERR.
- Sits between CPU/DMA masters and the shared peripheral interconnect.
- Successor to the single-master bus definition:
  - byte-lane SEL of DATA_WIDTH/8;
  - N channels;
  - error signalling.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_rr_picker.sv | 31 +++
 rtl/wb_arbiter_rr.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the Wishbone round-robin arbiter.
// Provides the arbiter state enum, the SEL width helper and the default timeout.
package wb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } wb_arb_state_e;

  localparam int WB_DEFAULT_TIMEOUT = 255;

  function automatic int wb_sel_width(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: combinational round-robin picker.
// Ports: req[N] requests, ptr start index, gnt[N] one-hot first req at/after ptr (wrapping).
module wb_rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      for (int k = 0; k < N; k++) begin
        if (!found && k == idx && req[k]) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: N-master to 1-slave Wishbone classic arbiter, round-robin,
// grant held for the whole CYC, per-transfer watchdog raising ERR.
// Ports: clk_i/rst_i; m_* packed master buses (master k at slice k);
// s_* single slave bus; m_dat_o broadcast read data; grant_o one-hot owner.
module wb_arbiter_rr
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = WB_DEFAULT_TIMEOUT
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic [NUM_MASTERS-1:0]                           m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                           m_stb_i,
  input  logic [NUM_MASTERS-1:0]                           m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]                m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]                m_dat_i,
  input  logic [NUM_MASTERS*wb_sel_width(DATA_WIDTH)-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]                            m_dat_o,
  output logic [NUM_MASTERS-1:0]                           m_ack_o,
  output logic [NUM_MASTERS-1:0]                           m_err_o,
  output logic                                             s_cyc_o,
  output logic                                             s_stb_o,
  output logic                                             s_we_o,
  output logic [ADDR_WIDTH-1:0]                            s_adr_o,
  output logic [DATA_WIDTH-1:0]                            s_dat_o,
  output logic [wb_sel_width(DATA_WIDTH)-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]                            s_dat_i,
  input  logic                                             s_ack_i,
  input  logic                                             s_err_i,
  output logic [NUM_MASTERS-1:0]                           grant_o
);

  localparam int N  = NUM_MASTERS;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = wb_sel_width(DATA_WIDTH);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  wb_arb_state_e state;
  logic [N-1:0]  grant;
  logic [N-1:0]  pick;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          owned;
  logic          own_cyc;
  logic          own_stb;
  logic          own_we;
  logic          rel;
  logic          stall;
  logic          wd_err;

  wb_rr_picker #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (ptr),
    .gnt (pick)
  );

  // grant is one-hot in OWNED and zero otherwise, so the mux needs no default owner
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    ptr_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) begin
        own_cyc = m_cyc_i[k];
        own_stb = m_stb_i[k];
        own_we  = m_we_i[k];
        s_adr_o = m_adr_i[k*AW +: AW];
        s_dat_o = m_dat_i[k*DW +: DW];
        s_sel_o = m_sel_i[k*SW +: SW];
        ptr_nxt = (k == N-1) ? '0 : PW'(k + 1);
      end
    end
  end

  assign owned   = (state == OWNED);
  assign s_cyc_o = owned & own_cyc;
  assign s_stb_o = s_cyc_o & own_stb;
  assign s_we_o  = s_cyc_o & own_we;
  assign rel     = owned & ~own_cyc;
  assign stall   = s_stb_o & ~s_ack_i & ~s_err_i;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant & {N{owned & s_ack_i}};
  assign m_err_o = grant & {N{owned & (s_err_i | wd_err)}};
  assign grant_o = grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|m_cyc_i) begin
            grant <= pick;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (rel) begin
            grant <= '0;
            ptr   <= ptr_nxt;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  if (TIMEOUT > 0) begin : g_wd
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WDW-1:0] wd_cnt;

    // fires on the TIMEOUT-th consecutive stalled cycle, then restarts
    assign wd_err = stall && (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wd_cnt <= '0;
      end else if (!stall || wd_err) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WDW'(1);
      end
    end
  end else begin : g_nowd
    assign wd_err = 1'b0;
  end

endmodule
